// File: rtl/crossbar_pkg.sv
// Shared types and defaults for the stream crossbar arbitration logic.
package crossbar_pkg;

  localparam int DEF_S_DATA_COUNT = 2;
  localparam int DEF_M_DATA_COUNT = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

endpackage

// File: rtl/stream_arbiter_unit_rr_arbiter.sv
// Round-robin packet arbiter for a single output: picks one requester and
// holds it until the end-of-packet handshake, then idles for one cycle.
module rr_arbiter
  import crossbar_pkg::*;
#(
  parameter  int S_DATA_COUNT = DEF_S_DATA_COUNT,
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_DATA_COUNT-1:0] req,
  input  logic                    eop,
  output logic [T_ID___WIDTH-1:0] grant,
  output logic                    locked,
  output logic [S_DATA_COUNT-1:0] claim,
  output logic [S_DATA_COUNT-1:0] free
);

  arb_state_e              state;
  logic [T_ID___WIDTH-1:0] ptr;
  logic [T_ID___WIDTH-1:0] winner;
  logic [T_ID___WIDTH-1:0] cand;
  logic [T_ID___WIDTH-1:0] next_ptr;
  logic                    found;

  localparam logic [T_ID___WIDTH-1:0] LAST_IDX = T_ID___WIDTH'(S_DATA_COUNT - 1);

  // Scan from ptr upward, wrapping at S_DATA_COUNT rather than 2^T_ID___WIDTH.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = ptr;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + T_ID___WIDTH'(1);
    end
  end

  assign next_ptr = (winner == LAST_IDX) ? '0 : winner + T_ID___WIDTH'(1);

  always_comb begin
    claim = '0;
    free  = '0;
    if (state == ARB_IDLE && found) claim[winner] = 1'b1;
    if (state == ARB_BUSY && eop)   free[grant]   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      locked <= 1'b0;
      ptr    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            grant  <= winner;
            ptr    <= next_ptr;
            locked <= 1'b1;
            state  <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // Release always lands in IDLE, so a new grant waits one cycle.
          if (eop) begin
            locked <= 1'b0;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stream_arbiter_unit.sv
// Per-output packet arbiters for the stream crossbar, with a shared
// input-ownership register so no input is granted to two outputs at once.
module stream_arbiter_unit
  import crossbar_pkg::*;
#(
  parameter  int S_DATA_COUNT = DEF_S_DATA_COUNT,
  parameter  int M_DATA_COUNT = DEF_M_DATA_COUNT,
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_in,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]  s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
  input  logic [M_DATA_COUNT-1:0]                    m_valid_i,
  input  logic [M_DATA_COUNT-1:0]                    m_ready_i,
  input  logic [M_DATA_COUNT-1:0]                    m_last_i,
  output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]  grant_o,
  output logic [M_DATA_COUNT-1:0]                    arbiter_ready_o,
  output logic [S_DATA_COUNT-1:0]                    s_busy_o
);

  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req;
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] claim;
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] free;
  logic [M_DATA_COUNT-1:0]                   eop;
  logic [S_DATA_COUNT-1:0]                   claim_any;
  logic [S_DATA_COUNT-1:0]                   free_any;

  assign eop = m_valid_i & m_ready_i & m_last_i;

  // Owned inputs are masked, so each input requests at most one free output.
  always_comb begin
    req = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      for (int s = 0; s < S_DATA_COUNT; s++) begin
        req[m][s] = s_valid_i[s] && (s_dest_i[s] == T_DEST_WIDTH'(m)) && !s_busy_o[s];
      end
    end
  end

  for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_arb
    rr_arbiter #(
      .S_DATA_COUNT (S_DATA_COUNT)
    ) u_arb (
      .clk    (clk_i),
      .rst_n  (rst_in),
      .req    (req[m]),
      .eop    (eop[m]),
      .grant  (grant_o[m]),
      .locked (arbiter_ready_o[m]),
      .claim  (claim[m]),
      .free   (free[m])
    );
  end

  always_comb begin
    claim_any = '0;
    free_any  = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      claim_any = claim_any | claim[m];
      free_any  = free_any  | free[m];
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      s_busy_o <= '0;
    end else begin
      s_busy_o <= (s_busy_o & ~free_any) | claim_any;
    end
  end

endmodule

// File: tb/tb_stream_arbiter_unit.sv
// Scoreboard bench for stream_arbiter_unit: a behavioural model predicts the
// registered outputs each cycle, plus directed checks from the test plan.
module tb_stream_arbiter_unit;

  localparam int S = 2;
  localparam int M = 3;

  logic                clk;
  logic                rst_n;
  logic [S-1:0][1:0]   s_dest;
  logic [S-1:0]        s_valid;
  logic [M-1:0]        m_valid;
  logic [M-1:0]        m_ready;
  logic [M-1:0]        m_last;
  logic [M-1:0][0:0]   grant;
  logic [M-1:0]        ready;
  logic [S-1:0]        busy;

  stream_arbiter_unit #(
    .S_DATA_COUNT (S),
    .M_DATA_COUNT (M)
  ) dut (
    .clk_i           (clk),
    .rst_in          (rst_n),
    .s_dest_i        (s_dest),
    .s_valid_i       (s_valid),
    .m_valid_i       (m_valid),
    .m_ready_i       (m_ready),
    .m_last_i        (m_last),
    .grant_o         (grant),
    .arbiter_ready_o (ready),
    .s_busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [M-1:0] grant;
    logic [M-1:0] ready;
    logic [S-1:0] busy;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  bit md_lock[M];
  int md_grant[M];
  int md_ptr[M];
  bit md_sbusy[S];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < M; m++) begin
      md_lock[m]  = 1'b0;
      md_grant[m] = 0;
      md_ptr[m]   = 0;
    end
    for (int s = 0; s < S; s++) md_sbusy[s] = 1'b0;
    sb.delete();
  endtask

  // Predict the state after the coming edge from the inputs now on the pins.
  task automatic model_step();
    bit   nl[M];
    int   ng[M];
    int   np[M];
    bit   nb[S];
    bit   found;
    int   w;
    int   cs;
    exp_t e;
    for (int m = 0; m < M; m++) begin
      nl[m] = md_lock[m];
      ng[m] = md_grant[m];
      np[m] = md_ptr[m];
    end
    for (int s = 0; s < S; s++) nb[s] = md_sbusy[s];
    for (int m = 0; m < M; m++) begin
      if (!md_lock[m]) begin
        found = 1'b0;
        w = 0;
        for (int i = 0; i < S; i++) begin
          cs = (md_ptr[m] + i) % S;
          if (!found && s_valid[cs] && (int'(s_dest[cs]) == m) && !md_sbusy[cs]) begin
            found = 1'b1;
            w = cs;
          end
        end
        if (found) begin
          nl[m] = 1'b1;
          ng[m] = w;
          np[m] = (w + 1) % S;
          nb[w] = 1'b1;
        end
      end else if (m_valid[m] && m_ready[m] && m_last[m]) begin
        nl[m] = 1'b0;
        nb[md_grant[m]] = 1'b0;
      end
    end
    for (int m = 0; m < M; m++) begin
      md_lock[m]  = nl[m];
      md_grant[m] = ng[m];
      md_ptr[m]   = np[m];
      e.grant[m]  = 1'(ng[m]);
      e.ready[m]  = nl[m];
    end
    for (int s = 0; s < S; s++) begin
      md_sbusy[s] = nb[s];
      e.busy[s]   = nb[s];
    end
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [S-1:0] sv, input logic [1:0] d0, input logic [1:0] d1,
                               input logic [M-1:0] mv, input logic [M-1:0] mr, input logic [M-1:0] ml);
    exp_t e;
    s_valid   = sv;
    s_dest[0] = d0;
    s_dest[1] = d1;
    m_valid   = mv;
    m_ready   = mr;
    m_last    = ml;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checkOutput("sb_grant", 32'(grant), 32'(e.grant));
    checkOutput("sb_ready", 32'(ready), 32'(e.ready));
    checkOutput("sb_busy",  32'(busy),  32'(e.busy));
  endtask

  task automatic idleCycle();
    applyStimulus('0, 2'd0, 2'd0, '0, '0, '0);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_grant"}, 32'(grant), 0);
    checkOutput({tag, "_ready"}, 32'(ready), 0);
    checkOutput({tag, "_busy"},  32'(busy),  0);
  endtask

  initial begin
    int  k;
    bit  prev;
    logic lk;

    rst_n   = 1'b0;
    s_valid = '0;
    s_dest  = '0;
    m_valid = '0;
    m_ready = '0;
    m_last  = '0;
    model_reset();

    #12;
    checkCleared("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idleCycle();
    idleCycle();
    checkCleared("rst_idle");

    // Single packet from input 0 to output 2.
    applyStimulus(2'b01, 2'd2, 2'd0, '0, '0, '0);
    checkOutput("sp_ready", 32'(ready), 3'b100);
    checkOutput("sp_grant2", 32'(grant[2]), 0);
    checkOutput("sp_busy", 32'(busy), 2'b01);
    idleCycle();
    idleCycle();
    idleCycle();
    applyStimulus('0, 2'd0, 2'd0, 3'b100, 3'b100, 3'b100);
    checkOutput("sp_rel_ready", 32'(ready), 0);
    checkOutput("sp_rel_busy", 32'(busy), 0);
    idleCycle();

    // Two outputs granted in parallel.
    applyStimulus(2'b11, 2'd0, 2'd2, '0, '0, '0);
    checkOutput("par_ready", 32'(ready), 3'b101);
    checkOutput("par_grant0", 32'(grant[0]), 0);
    checkOutput("par_grant2", 32'(grant[2]), 1);
    checkOutput("par_busy", 32'(busy), 2'b11);
    applyStimulus('0, 2'd0, 2'd0, 3'b101, 3'b101, 3'b101);
    checkOutput("par_rel_ready", 32'(ready), 0);
    idleCycle();

    // Input 0 owned by output 1 while its destination moves to output 0.
    applyStimulus(2'b01, 2'd1, 2'd0, '0, '0, '0);
    checkOutput("mask_lock", 32'(ready), 3'b010);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 2'd0, 2'd0, '0, '0, '0);
      checkOutput("mask_hold", 32'(ready), 3'b010);
    end
    applyStimulus(2'b01, 2'd0, 2'd0, 3'b010, 3'b010, 3'b010);
    checkOutput("mask_gap", 32'(ready), 0);
    applyStimulus(2'b01, 2'd0, 2'd0, '0, '0, '0);
    checkOutput("mask_regrant", 32'(ready), 3'b001);
    checkOutput("mask_grant0", 32'(grant[0]), 0);
    applyStimulus('0, 2'd0, 2'd0, 3'b001, 3'b001, 3'b001);
    idleCycle();

    // Asynchronous reset in the middle of a packet.
    applyStimulus(2'b10, 2'd0, 2'd1, '0, '0, '0);
    checkOutput("mrst_pre", 32'(ready), 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    checkCleared("mrst");
    model_reset();
    s_valid = '0;
    s_dest  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both inputs contend for output 1 with one-beat packets.
    k = 0;
    prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      lk = md_lock[1];
      applyStimulus(2'b11, 2'd1, 2'd1, {1'b0, lk, 1'b0}, {1'b0, lk, 1'b0}, {1'b0, lk, 1'b0});
      if (ready[1] && !prev) begin
        checkOutput("rr_order", 32'(grant[1]), k % 2);
        k++;
      end
      prev = ready[1];
    end
    checkOutput("rr_count", k, 6);

    // Random traffic against the model.
    for (int i = 0; i < 120; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
